// File: rtl/my_ram_fifo_cfg.sv
// rtl/my_ram_fifo_cfg.sv - configurable single-clock block RAM FIFO with standard/FWFT read
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_wren, i_wrdata         write request and data
//   o_full, o_almost_full    count == DEPTH, count >= AFULL_TH
//   o_overflow               one-cycle pulse after a write requested while full
//   i_rden                   read request (standard) or pop (FWFT)
//   o_rddata, o_valid        read data and its qualifier
//   o_empty, o_almost_empty  no readable word, count <= AEMPTY_TH
//   o_underflow              one-cycle pulse after a read requested while empty
//   o_count                  words written and not yet read
module my_ram_fifo_cfg #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wren,
    input  logic [DATA_W-1:0]          i_wrdata,
    output logic                       o_full,
    output logic                       o_almost_full,
    output logic                       o_overflow,
    input  logic                       i_rden,
    output logic [DATA_W-1:0]          o_rddata,
    output logic                       o_valid,
    output logic                       o_empty,
    output logic                       o_almost_empty,
    output logic                       o_underflow,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam bit FWFT_B = (FWFT != 0);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;

    logic [PTR_W-1:0]  wrptr_q, wrptr_d, rdptr_q, rdptr_d, ram_addr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              stall_q, stall_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              fwd_q, fwd_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic              empty, full, wr_acc, rd_acc, ram_en;

    always_comb begin
        // stall_q covers the cycle where a word written into an empty FWFT FIFO
        // has not yet reached the RAM output register.
        empty    = (count_q == '0) | stall_q;
        full     = (count_q == DEPTH_C);
        wr_acc   = i_wren & ~full;
        rd_acc   = i_rden & ~empty;
        wrptr_d  = wr_acc ? ptr_inc(wrptr_q) : wrptr_q;
        rdptr_d  = rd_acc ? ptr_inc(rdptr_q) : rdptr_q;
        count_d  = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // FWFT reads ahead every cycle at the next head; standard mode reads only on request.
        ram_en   = FWFT_B | rd_acc;
        ram_addr = FWFT_B ? rdptr_d : rdptr_q;
        stall_d  = FWFT_B & wr_acc & (count_q == '0);
        // Pop and write together at count 1: the new head is the word being written
        // this edge, which the RAM cannot return yet, so it is carried in a side register.
        fwd_d      = FWFT_B & wr_acc & rd_acc & (wrptr_q == rdptr_d);
        fwd_data_d = i_wrdata;
        valid_d  = ~FWFT_B & rd_acc;
        ovf_d    = i_wren & full;
        unf_d    = i_rden & empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            count_q <= '0;
            stall_q <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            fwd_q   <= 1'b0;
        end else begin
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            count_q <= count_d;
            stall_q <= stall_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            fwd_q   <= fwd_d;
        end
    end

    // Simple dual-port RAM with registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wrptr_q] <= i_wrdata;
        end
        if (ram_en) begin
            ram_q <= mem[ram_addr];
        end
        fwd_data_q <= fwd_data_d;
    end

    assign o_rddata       = fwd_q ? fwd_data_q : ram_q;
    assign o_valid        = FWFT_B ? ~empty : valid_q;
    assign o_empty        = empty;
    assign o_full         = full;
    assign o_almost_full  = (count_q >= AFULL_C);
    assign o_almost_empty = (count_q <= AEMPTY_C);
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;
    assign o_count        = count_q;

endmodule

// File: tb/tb_my_ram_fifo_cfg.sv
// tb/tb_my_ram_fifo_cfg.sv - scoreboard bench for my_ram_fifo_cfg
module tb_my_ram_fifo_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [3:0]      wren, rden, full, afull, ovf, vld, empty, aempty, unf;
    logic [3:0][7:0] wdat, rdat;
    logic [4:0]      cnt_a, cnt_b;
    logic [2:0]      cnt_c, cnt_d;

    int nchk  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    // 0: DEPTH16 standard, 1: DEPTH16 FWFT, 2: DEPTH5 standard, 3: DEPTH5 FWFT
    my_ram_fifo_cfg #(.DATA_W(8), .DEPTH(16), .FWFT(0), .AFULL_TH(14), .AEMPTY_TH(2)) u_a (
        .clk(clk), .rst(rst), .i_wren(wren[0]), .i_wrdata(wdat[0]), .o_full(full[0]),
        .o_almost_full(afull[0]), .o_overflow(ovf[0]), .i_rden(rden[0]), .o_rddata(rdat[0]),
        .o_valid(vld[0]), .o_empty(empty[0]), .o_almost_empty(aempty[0]),
        .o_underflow(unf[0]), .o_count(cnt_a));
    my_ram_fifo_cfg #(.DATA_W(8), .DEPTH(16), .FWFT(1), .AFULL_TH(14), .AEMPTY_TH(2)) u_b (
        .clk(clk), .rst(rst), .i_wren(wren[1]), .i_wrdata(wdat[1]), .o_full(full[1]),
        .o_almost_full(afull[1]), .o_overflow(ovf[1]), .i_rden(rden[1]), .o_rddata(rdat[1]),
        .o_valid(vld[1]), .o_empty(empty[1]), .o_almost_empty(aempty[1]),
        .o_underflow(unf[1]), .o_count(cnt_b));
    my_ram_fifo_cfg #(.DATA_W(8), .DEPTH(5), .FWFT(0), .AFULL_TH(4), .AEMPTY_TH(1)) u_c (
        .clk(clk), .rst(rst), .i_wren(wren[2]), .i_wrdata(wdat[2]), .o_full(full[2]),
        .o_almost_full(afull[2]), .o_overflow(ovf[2]), .i_rden(rden[2]), .o_rddata(rdat[2]),
        .o_valid(vld[2]), .o_empty(empty[2]), .o_almost_empty(aempty[2]),
        .o_underflow(unf[2]), .o_count(cnt_c));
    my_ram_fifo_cfg #(.DATA_W(8), .DEPTH(5), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(1)) u_d (
        .clk(clk), .rst(rst), .i_wren(wren[3]), .i_wrdata(wdat[3]), .o_full(full[3]),
        .o_almost_full(afull[3]), .o_overflow(ovf[3]), .i_rden(rden[3]), .o_rddata(rdat[3]),
        .o_valid(vld[3]), .o_empty(empty[3]), .o_almost_empty(aempty[3]),
        .o_underflow(unf[3]), .o_count(cnt_d));

    function automatic int dep(int i);
        return (i < 2) ? 16 : 5;
    endfunction
    function automatic bit is_fwft(int i);
        return (i == 1) || (i == 3);
    endfunction
    function automatic int afth(int i);
        case (i)
            0, 1:    return 14;
            2:       return 4;
            default: return 3;
        endcase
    endfunction
    function automatic int aeth(int i);
        return (i < 2) ? 2 : 1;
    endfunction
    function automatic logic [31:0] cnt_of(int i);
        case (i)
            0:       return 32'(cnt_a);
            1:       return 32'(cnt_b);
            2:       return 32'(cnt_c);
            default: return 32'(cnt_d);
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state, advanced at each rising edge from the applied inputs.
    int         m_cnt  [4];
    bit         m_stall[4];
    bit         m_ovf  [4];
    bit         m_unf  [4];
    bit         m_vld  [4];
    logic [7:0] ref_q  [4][$];
    logic [7:0] exp_q  [4][$];

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            bit e, f, wa, ra;
            e = (m_cnt[i] == 0) || m_stall[i];
            f = (m_cnt[i] == dep(i));
            if (rst) begin
                m_cnt[i]   = 0;
                m_stall[i] = 1'b0;
                m_ovf[i]   = 1'b0;
                m_unf[i]   = 1'b0;
                m_vld[i]   = 1'b0;
                ref_q[i].delete();
                exp_q[i].delete();
            end else begin
                wa = wren[i] && !f;
                ra = rden[i] && !e;
                m_ovf[i]   = wren[i] && f;
                m_unf[i]   = rden[i] && e;
                m_stall[i] = is_fwft(i) && wa && (m_cnt[i] == 0);
                m_vld[i]   = !is_fwft(i) && ra;
                if (ra && !is_fwft(i)) exp_q[i].push_back(ref_q[i].pop_front());
                if (wa) begin
                    if (is_fwft(i)) exp_q[i].push_back(wdat[i]);
                    else            ref_q[i].push_back(wdat[i]);
                end
                m_cnt[i] = m_cnt[i] + int'(wa) - int'(ra);
            end
        end
    end

    // Monitor: flags and count every cycle; data popped whenever the DUT presents a word.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                logic [6:0] ef, af;
                bit ee;
                ee = (m_cnt[i] == 0) || m_stall[i];
                ef = {m_cnt[i] == dep(i), m_cnt[i] >= afth(i), ee, m_cnt[i] <= aeth(i),
                      m_ovf[i], m_unf[i], is_fwft(i) ? !ee : m_vld[i]};
                af = {full[i], afull[i], empty[i], aempty[i], ovf[i], unf[i], vld[i]};
                check($sformatf("flags%0d{full,af,empty,ae,ovf,unf,vld}", i), 32'(af), 32'(ef));
                check($sformatf("count%0d", i), cnt_of(i), 32'(m_cnt[i]));
                if (vld[i] === 1'b1 && (!is_fwft(i) || rden[i] === 1'b1)) begin
                    if (exp_q[i].size() == 0) begin
                        nchk++;
                        nfail++;
                        $display("FAIL data%0d: output 0x%02h with nothing expected at %0t", i, rdat[i], $time);
                    end else begin
                        check($sformatf("data%0d", i), 32'(rdat[i]), 32'(exp_q[i].pop_front()));
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        wren = '0;
        rden = '0;
        wdat = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;

        check("rst_count", 32'(cnt_a), 0);
        check("rst_empty", 32'(empty[0]), 1);
        check("rst_aempty", 32'(aempty[0]), 1);
        check("rst_full", 32'(full[0]), 0);
        check("rst_afull", 32'(afull[0]), 0);
        check("rst_valid", 32'(vld[0]), 0);

        // Fill standard 16-deep FIFO with 0x01..0x10, then one overflowing write.
        for (int k = 1; k <= 16; k++) begin
            wren[0] = 1'b1;
            wdat[0] = 8'(k);
            cyc();
            check($sformatf("fill_afull_%0d", k), 32'(afull[0]), 32'(k >= 14));
            check($sformatf("fill_full_%0d", k), 32'(full[0]), 32'(k == 16));
        end
        check("fill_count", 32'(cnt_a), 16);
        wdat[0] = 8'h11;
        cyc();
        check("ovf_pulse", 32'(ovf[0]), 1);
        check("ovf_count", 32'(cnt_a), 16);
        wren[0] = 1'b0;
        cyc();
        check("ovf_clear", 32'(ovf[0]), 0);

        // Back-to-back drain, then one underflowing read.
        for (int k = 1; k <= 16; k++) begin
            rden[0] = 1'b1;
            cyc();
            check($sformatf("drain_data_%0d", k), 32'(rdat[0]), 32'(k));
            check($sformatf("drain_vld_%0d", k), 32'(vld[0]), 1);
            check($sformatf("drain_count_%0d", k), 32'(cnt_a), 32'(16 - k));
        end
        check("drain_empty", 32'(empty[0]), 1);
        cyc();
        check("unf_pulse", 32'(unf[0]), 1);
        check("unf_novalid", 32'(vld[0]), 0);
        rden[0] = 1'b0;
        cyc();
        check("unf_clear", 32'(unf[0]), 0);

        // Almost-empty threshold 2: count 0->3->0.
        for (int k = 1; k <= 3; k++) begin
            wren[0] = 1'b1;
            wdat[0] = 8'(8'h20 + k);
            cyc();
            check($sformatf("ae_up_%0d", k), 32'(aempty[0]), 32'(k < 3));
        end
        wren[0] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            rden[0] = 1'b1;
            cyc();
            check($sformatf("ae_down_cnt_%0d", k), 32'(cnt_a), 32'(3 - k));
            check($sformatf("ae_down_%0d", k), 32'(aempty[0]), 1);
        end
        rden[0] = 1'b0;
        cyc();

        // FWFT latency: write 0xA5 into empty FIFO.
        wren[1] = 1'b1;
        wdat[1] = 8'hA5;
        cyc();
        wren[1] = 1'b0;
        check("fwft_t_empty", 32'(empty[1]), 1);
        check("fwft_t_count", 32'(cnt_b), 1);
        cyc();
        check("fwft_t1_empty", 32'(empty[1]), 0);
        check("fwft_t1_data", 32'(rdat[1]), 32'h A5);
        rden[1] = 1'b1;
        cyc();
        rden[1] = 1'b0;
        check("fwft_pop_empty", 32'(empty[1]), 1);

        // Simultaneous requests on DEPTH=5 instances at count 0, 1 and DEPTH.
        wren[3:2] = 2'b11; rden[3:2] = 2'b11; wdat[2] = 8'h40; wdat[3] = 8'h40;
        cyc();
        check("c0_cnt_c", 32'(cnt_c), 1);
        check("c0_cnt_d", 32'(cnt_d), 1);
        check("c0_unf_c", 32'(unf[2]), 1);
        check("c0_unf_d", 32'(unf[3]), 1);
        wren[3:2] = 2'b00; rden[3:2] = 2'b00;
        cyc();
        check("c0_vis_d", 32'(empty[3]), 0);
        wren[3:2] = 2'b11; rden[3:2] = 2'b11; wdat[2] = 8'h41; wdat[3] = 8'h41;
        cyc();
        check("c1_cnt_c", 32'(cnt_c), 1);
        check("c1_cnt_d", 32'(cnt_d), 1);
        check("c1_data_c", 32'(rdat[2]), 32'h40);
        check("c1_empty_d", 32'(empty[3]), 0);
        check("c1_data_d", 32'(rdat[3]), 32'h41);
        rden[3:2] = 2'b00;
        for (int k = 2; k <= 5; k++) begin
            wdat[2] = 8'(8'h40 + k);
            wdat[3] = 8'(8'h40 + k);
            cyc();
        end
        check("cf_full_c", 32'(full[2]), 1);
        check("cf_full_d", 32'(full[3]), 1);
        rden[3:2] = 2'b11; wdat[2] = 8'h46; wdat[3] = 8'h46;
        cyc();
        check("cf_cnt_c", 32'(cnt_c), 4);
        check("cf_cnt_d", 32'(cnt_d), 4);
        check("cf_ovf_c", 32'(ovf[2]), 1);
        check("cf_ovf_d", 32'(ovf[3]), 1);
        wren[3:2] = 2'b00; rden[3:2] = 2'b00;
        cyc();

        // Random traffic with alternating write-heavy and read-heavy phases.
        for (int c = 0; c < 200; c++) begin
            int wp;
            wp = ((c / 20) % 2 == 0) ? 70 : 30;
            for (int i = 2; i < 4; i++) begin
                wren[i] = ($urandom_range(0, 99) < wp);
                rden[i] = ($urandom_range(0, 99) < (100 - wp));
                wdat[i] = 8'($urandom);
            end
            cyc();
        end
        wren[3:2] = 2'b00;
        rden[3:2] = 2'b11;
        repeat (8) cyc();
        rden[3:2] = 2'b00;
        cyc();

        // Mid-operation reset at count 9 in FWFT mode.
        for (int k = 0; k < 9; k++) begin
            wren[1] = 1'b1;
            wdat[1] = 8'(8'h50 + k);
            cyc();
        end
        wren[1] = 1'b0;
        check("mr_count9", 32'(cnt_b), 9);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mr_count", 32'(cnt_b), 0);
        check("mr_empty", 32'(empty[1]), 1);
        check("mr_aempty", 32'(aempty[1]), 1);
        check("mr_full", 32'(full[1]), 0);
        check("mr_afull", 32'(afull[1]), 0);
        check("mr_ovf", 32'(ovf[1]), 0);
        check("mr_unf", 32'(unf[1]), 0);
        check("mr_valid", 32'(vld[1]), 0);
        wren[1] = 1'b1;
        wdat[1] = 8'h3C;
        cyc();
        wren[1] = 1'b0;
        cyc();
        check("mr_new_valid", 32'(vld[1]), 1);
        check("mr_new_data", 32'(rdat[1]), 32'h3C);
        rden[1] = 1'b1;
        cyc();
        rden[1] = 1'b0;
        check("mr_pop_empty", 32'(empty[1]), 1);
        repeat (3) cyc();

        for (int i = 0; i < 4; i++) begin
            check($sformatf("sb_drained%0d", i), 32'(exp_q[i].size()), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
